// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin quantum arbiter.
package arb_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Cyclic first-set-bit picker: scans req&mask starting at ptr, wrapping at N-1 -> 0.
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic [N-1:0]     mask,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0] cand;
    assign cand = req & mask;

    // Wrapped candidates (below ptr) are written first so any candidate at or above ptr
    // overrides them; within each group the descending scan leaves the lowest index.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i] && (IDX_W'(i) < ptr)) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i] && (IDX_W'(i) >= ptr)) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_quantum_arbiter.sv
// Round-robin arbiter with a hold quantum: owners keep the grant while requesting,
// but are preempted after QUANTUM granted cycles when someone else is waiting.
module rr_quantum_arbiter
    import arb_pkg::*;
#(
    parameter  int N       = 3,
    parameter  int QUANTUM = 8,
    localparam int IDX_W   = (N > 1) ? $clog2(N) : 1,
    localparam int CNT_W   = (QUANTUM > 0) ? $clog2(QUANTUM + 1) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     r,
    output logic [N-1:0]     g,
    output logic             busy,
    output logic [IDX_W-1:0] owner,
    output logic             preempt
);

    arb_state_t       state_q, state_n;
    logic [IDX_W-1:0] ptr_q, ptr_n, owner_n, owner_nxt, pick_ptr, pick_idx;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [N-1:0]     g_n, owner_oh, pick_mask;
    logic             preempt_n, pick_valid, in_grant;

    assign in_grant  = (state_q == GRANT);
    assign owner_oh  = N'(1) << owner;
    assign owner_nxt = IDX_W'(rr_next(int'(owner), N));

    // One picker serves both the free-state arbitration and the owner handover.
    assign pick_ptr  = in_grant ? owner_nxt : ptr_q;
    assign pick_mask = in_grant ? ~owner_oh : '1;

    rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
        .req   (r),
        .ptr   (pick_ptr),
        .mask  (pick_mask),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_n   = state_q;
        ptr_n     = ptr_q;
        cnt_n     = cnt_q;
        owner_n   = owner;
        g_n       = g;
        preempt_n = 1'b0;
        case (state_q)
            IDLE, RELEASE: begin
                if (pick_valid) begin
                    state_n = GRANT;
                    owner_n = pick_idx;
                    g_n     = N'(1) << pick_idx;
                    cnt_n   = CNT_W'(1);
                end else begin
                    state_n = IDLE;
                    g_n     = '0;
                end
            end
            GRANT: begin
                if (!(|(r & owner_oh))) begin
                    ptr_n = owner_nxt;
                    if (pick_valid) begin
                        owner_n = pick_idx;
                        g_n     = N'(1) << pick_idx;
                        cnt_n   = CNT_W'(1);
                    end else begin
                        state_n = IDLE;
                        g_n     = '0;
                    end
                end else if (QUANTUM != 0 && cnt_q == CNT_W'(QUANTUM) && (|(r & ~owner_oh))) begin
                    state_n   = RELEASE;
                    g_n       = '0;
                    ptr_n     = owner_nxt;
                    preempt_n = 1'b1;
                end else if (QUANTUM != 0 && cnt_q < CNT_W'(QUANTUM)) begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                g_n     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            owner   <= '0;
            g       <= '0;
            busy    <= 1'b0;
            preempt <= 1'b0;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            cnt_q   <= cnt_n;
            owner   <= owner_n;
            g       <= g_n;
            busy    <= |g_n;
            preempt <= preempt_n;
        end
    end

endmodule

// File: tb/tb_rr_quantum_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-free
// behavioural model of the round-robin / quantum rules.
module tb_rr_quantum_arbiter;

    localparam int N = 3;
    localparam int Q = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] r = '0;
    logic [N-1:0] g;
    logic         busy;
    logic [1:0]   owner;
    logic         preempt;

    int n_cmp = 0;
    int n_err = 0;

    // model: current owner (-1 = nobody), granted cycles so far, scan start, preempt pulse
    int m_owner, m_held, m_ptr;
    bit m_pre;

    rr_quantum_arbiter #(.N(N), .QUANTUM(Q)) dut (
        .clk     (clk),
        .reset   (reset),
        .r       (r),
        .g       (g),
        .busy    (busy),
        .owner   (owner),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    function automatic bit bit_of(input logic [N-1:0] v, input int j);
        logic [N-1:0] s;
        s = v >> j;
        return s[0];
    endfunction

    function automatic int pick_m(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            if (bit_of(v, (start + k) % N)) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_g();
        logic [N-1:0] one;
        one = 1;
        return (m_owner >= 0) ? (one << m_owner) : '0;
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
        m_pre   = 1'b0;
    endfunction

    function automatic void model_step(input logic [N-1:0] v);
        logic [N-1:0] others;
        m_pre = 1'b0;
        if (m_owner < 0) begin
            m_owner = pick_m(v, m_ptr);
            m_held  = 1;
        end else if (!bit_of(v, m_owner)) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = pick_m(v, m_ptr);
            m_held  = 1;
        end else begin
            others = v;
            others = others & ~(exp_g());
            if (Q != 0 && m_held >= Q && others != 0) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_pre   = 1'b1;
            end else begin
                m_held++;
            end
        end
    endfunction

    // Drive r just after an edge, advance one clock, update the model, settle 1 time unit.
    task automatic step(input logic [N-1:0] v);
        r = v;
        @(posedge clk);
        model_step(v);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        r     = '0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        r     = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (g !== 3'b000)  begin n_err++; $display("FAIL reset_g: got %b want 000", g); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (owner !== 2'd0) begin n_err++; $display("FAIL reset_owner: got %0d want 0", owner); end
        n_cmp++; if (preempt !== 1'b0) begin n_err++; $display("FAIL reset_preempt: got %b want 0", preempt); end
        reset = 1'b0;
        model_reset();
        step(3'b111);
        n_cmp++; if (g !== 3'b001) begin n_err++; $display("FAIL reset_first_grant: got %b want 001", g); end
        n_cmp++; if (owner !== 2'd0) begin n_err++; $display("FAIL reset_first_owner: got %0d want 0", owner); end
    endtask

    task automatic test_single_hold();
        int bad;
        do_reset();
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            step(3'b001);
            if (g !== 3'b001 || preempt !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL single_hold: %0d bad cycles, want 0", bad); end
        step(3'b000);
        n_cmp++; if (g !== 3'b000 || busy !== 1'b0) begin
            n_err++; $display("FAIL single_drop: got g=%b busy=%b want g=000 busy=0", g, busy);
        end
    endtask

    task automatic test_quantum();
        logic [N-1:0] want;
        logic         wpre;
        do_reset();
        for (int c = 1; c <= 19; c++) begin
            step(3'b011);
            want = (c <= 8) ? 3'b001 : (c == 9) ? 3'b000 : (c <= 17) ? 3'b010 : (c == 18) ? 3'b000 : 3'b001;
            wpre = (c == 9 || c == 18);
            n_cmp++; if (g !== want || preempt !== wpre) begin
                n_err++; $display("FAIL quantum_c%0d: got g=%b pre=%b want g=%b pre=%b", c, g, preempt, want, wpre);
            end
        end
    endtask

    task automatic test_handover();
        do_reset();
        step(3'b001);
        step(3'b100);
        n_cmp++; if (g !== 3'b100 || preempt !== 1'b0 || owner !== 2'd2) begin
            n_err++; $display("FAIL handover: got g=%b pre=%b owner=%0d want g=100 pre=0 owner=2", g, preempt, owner);
        end
    endtask

    task automatic test_deassert_at_quantum();
        do_reset();
        repeat (Q) step(3'b011);
        n_cmp++; if (g !== 3'b001) begin n_err++; $display("FAIL dq_hold: got %b want 001", g); end
        step(3'b010);
        n_cmp++; if (g !== 3'b010 || preempt !== 1'b0) begin
            n_err++; $display("FAIL dq_handover: got g=%b pre=%b want g=010 pre=0", g, preempt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(3'b010);
        n_cmp++; if (g !== 3'b010) begin n_err++; $display("FAIL ar_grant: got %b want 010", g); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (g !== 3'b000 || busy !== 1'b0) begin
            n_err++; $display("FAIL ar_async_drop: got g=%b busy=%b want g=000 busy=0", g, busy);
        end
        r = 3'b110;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        step(3'b110);
        n_cmp++; if (g !== 3'b010 || owner !== 2'd1) begin
            n_err++; $display("FAIL ar_regrant: got g=%b owner=%0d want g=010 owner=1", g, owner);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        int bad_g, bad_p, bad_b, bad_o, bad_inv;
        do_reset();
        v = '0;
        bad_g = 0; bad_p = 0; bad_b = 0; bad_o = 0; bad_inv = 0;
        for (int c = 0; c < 600; c++) begin
            // sticky requests: each line toggles with roughly 1-in-6 odds per cycle
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(5) == 0) v = v ^ (3'b001 << b);
            end
            step(v);
            if (g !== exp_g()) begin
                bad_g++;
                if (bad_g <= 3) $display("FAIL rand_g c=%0d: got %b want %b", c, g, exp_g());
            end
            if (preempt !== m_pre) bad_p++;
            if (busy !== (m_owner >= 0)) bad_b++;
            if (m_owner >= 0 && int'(owner) != m_owner) bad_o++;
            if (!$onehot0(g) || (preempt && g != 0)) bad_inv++;
        end
        n_cmp++; if (bad_g != 0)   begin n_err++; $display("FAIL rand_grant: %0d bad cycles, want 0", bad_g); end
        n_cmp++; if (bad_p != 0)   begin n_err++; $display("FAIL rand_preempt: %0d bad cycles, want 0", bad_p); end
        n_cmp++; if (bad_b != 0)   begin n_err++; $display("FAIL rand_busy: %0d bad cycles, want 0", bad_b); end
        n_cmp++; if (bad_o != 0)   begin n_err++; $display("FAIL rand_owner: %0d bad cycles, want 0", bad_o); end
        n_cmp++; if (bad_inv != 0) begin n_err++; $display("FAIL rand_invariant: %0d bad cycles, want 0", bad_inv); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_hold();
        test_quantum();
        test_handover();
        test_deassert_at_quantum();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
